// File: rtl/midi_msg_decoder.sv
// MIDI channel-voice message decoder: turns the UART receiver's byte stream into
// one-cycle decoded events, with running status, channel filtering and realtime pass-through.
module midi_msg_decoder #(
    parameter logic [3:0] DEFAULT_CH       = 4'd0,
    parameter bit         NOTEON_V0_IS_OFF = 1'b1
) (
    input  logic       CLOCK_25,
    input  logic       iRST_N,
    input  logic       byteready,
    input  logic [7:0] midibyte,
    input  logic       sys_real,
    input  logic [7:0] sys_real_dat,
    input  logic       omni,
    input  logic [3:0] midi_ch,
    output logic       evt_valid,
    output logic [2:0] evt_type,
    output logic [3:0] evt_chan,
    output logic [6:0] evt_d1,
    output logic [6:0] evt_d2,
    output logic       rt_valid,
    output logic [7:0] rt_byte,
    output logic [7:0] status_o
);

    typedef enum logic [1:0] {NO_STATUS, WAIT_D1, WAIT_D2, SYSEX} state_t;

    state_t     state;
    logic [2:0] br_sync;   // [1:0] synchroniser, [2] previous value for edge detect
    logic [2:0] sr_sync;
    logic       stb_q;
    logic [7:0] byte_q;
    logic [6:0] d1_q;
    logic [3:0] ch_q;

    logic       byte_stb;
    logic       rt_stb;
    logic       is_status;
    logic       is_data;
    logic       one_data;
    logic       msg_done;
    logic       accept;
    logic [6:0] d1_c;
    logic [6:0] d2_c;
    logic [2:0] type_c;

    assign byte_stb  = br_sync[1] & ~br_sync[2];
    assign rt_stb    = sr_sync[1] & ~sr_sync[2];
    assign is_status = byte_q[7] && (byte_q < 8'hF0);
    assign is_data   = ~byte_q[7];
    assign one_data  = (status_o[7:4] == 4'hC) || (status_o[7:4] == 4'hD);
    assign msg_done  = stb_q && is_data &&
                       (((state == WAIT_D1) && one_data) || (state == WAIT_D2));
    assign accept    = omni || (status_o[3:0] == ch_q);
    assign d1_c      = (state == WAIT_D2) ? d1_q : byte_q[6:0];
    assign d2_c      = (state == WAIT_D2) ? byte_q[6:0] : 7'd0;
    // status[6:4] runs 0..6 for 0x8_..0xE_, which is exactly the event type code
    assign type_c    = (NOTEON_V0_IS_OFF && (status_o[6:4] == 3'd1) && (d2_c == 7'd0))
                       ? 3'd0 : status_o[6:4];

    always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
        if (!iRST_N) begin
            br_sync  <= '0;
            sr_sync  <= '0;
            stb_q    <= 1'b0;
            byte_q   <= '0;
            ch_q     <= DEFAULT_CH;
            rt_valid <= 1'b0;
            rt_byte  <= '0;
        end else begin
            br_sync  <= {br_sync[1:0], byteready};
            sr_sync  <= {sr_sync[1:0], sys_real};
            stb_q    <= byte_stb;
            ch_q     <= midi_ch;
            rt_valid <= rt_stb;
            if (byte_stb) byte_q <= midibyte;
            if (rt_stb)   rt_byte <= sys_real_dat;
        end
    end

    always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= NO_STATUS;
            status_o  <= '0;
            d1_q      <= '0;
            evt_valid <= 1'b0;
            evt_type  <= '0;
            evt_chan  <= '0;
            evt_d1    <= '0;
            evt_d2    <= '0;
        end else begin
            evt_valid <= 1'b0;
            // realtime bytes arriving through midibyte never touch the parser
            if (stb_q && (byte_q < 8'hF8)) begin
                if (is_status) begin
                    status_o <= byte_q;
                    state    <= WAIT_D1;
                end else if (byte_q == 8'hF0) begin
                    status_o <= '0;
                    state    <= SYSEX;
                end else if (byte_q[7]) begin
                    status_o <= '0;
                    state    <= NO_STATUS;
                end else begin
                    case (state)
                        WAIT_D1: begin
                            d1_q <= byte_q[6:0];
                            if (!one_data) state <= WAIT_D2;
                        end
                        WAIT_D2: state <= WAIT_D1;
                        default: ;
                    endcase
                end
                if (msg_done && accept) begin
                    evt_valid <= 1'b1;
                    evt_type  <= type_c;
                    evt_chan  <= status_o[3:0];
                    evt_d1    <= d1_c;
                    evt_d2    <= d2_c;
                end
            end
        end
    end

endmodule
